// File: rtl/parl_add_pkg.sv
// Shared widths, latency and extension helper for the five-operand adder.
// PARL_ADD_SIGNED_EN selects two's-complement operands.
package parl_add_pkg;

  localparam int OPERAND_WIDTH_DEF = 19;
  localparam int OUTPUT_WIDTH_DEF  = 22;
  localparam int PARL_ADD_LATENCY  = 3;
  localparam int PARL_ADD_OPERANDS = 5;

`ifdef PARL_ADD_SIGNED_EN
  localparam bit PARL_ADD_SIGNED = 1'b1;
`else
  localparam bit PARL_ADD_SIGNED = 1'b0;
`endif

  // Extra MSBs needed so the sum of n_ops operands cannot wrap.
  function automatic int parl_ext_w(input int n_ops);
    return $clog2(n_ops);
  endfunction

endpackage

// File: rtl/parl_add_reg2.sv
// Registered two-input adder with sync active-low clear and
// selectable sign/zero extension of both operands to OUT_W.
module parl_add_reg2 #(
  parameter int A_W       = 8,
  parameter int B_W       = 8,
  parameter int OUT_W     = 9,
  parameter bit SIGNED_EN = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [OUT_W-1:0] sum_o
);

  logic             a_ext;
  logic             b_ext;
  logic [OUT_W-1:0] a_x;
  logic [OUT_W-1:0] b_x;
  logic [OUT_W-1:0] sum_d;
  logic [OUT_W-1:0] sum_q;

  if (OUT_W <= A_W || OUT_W <= B_W) begin : g_bad_w
    $error("parl_add_reg2: OUT_W must exceed both operand widths");
  end

  assign a_ext = SIGNED_EN & a_i[A_W-1];
  assign b_ext = SIGNED_EN & b_i[B_W-1];
  assign a_x   = {{(OUT_W-A_W){a_ext}}, a_i};
  assign b_x   = {{(OUT_W-B_W){b_ext}}, b_i};
  assign sum_d = a_x + b_x;

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/parallel_add_5.sv
// Three-stage pipelined a+b+c+d+e adder tree, one sum per clock.
// PARL_ADD_SIGNED_EN switches to two's-complement operands.
module parallel_add_5
  import parl_add_pkg::*;
#(
  parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
  parameter int OUTPUT_WIDTH  = OUTPUT_WIDTH_DEF
) (
  input  logic                     parl_add_top_clk,
  input  logic                     parl_add_top_rst_b,
  input  logic [OPERAND_WIDTH-1:0] parl_add_top_in_a_i,
  input  logic [OPERAND_WIDTH-1:0] parl_add_top_in_b_i,
  input  logic [OPERAND_WIDTH-1:0] parl_add_top_in_c_i,
  input  logic [OPERAND_WIDTH-1:0] parl_add_top_in_d_i,
  input  logic [OPERAND_WIDTH-1:0] parl_add_top_in_e_i,
  output logic [OUTPUT_WIDTH-1:0]  parl_add_top_out_o
);

  localparam int OW  = OPERAND_WIDTH;
  localparam int S1W = OW + 1;
  localparam int S2W = OW + 2;

  if (OUTPUT_WIDTH < OW + parl_ext_w(PARL_ADD_OPERANDS)) begin : g_bad_w
    $error("parallel_add_5: OUTPUT_WIDTH too small for five operands");
  end

  logic [S1W-1:0] s_ab;
  logic [S1W-1:0] s_cd;
  logic [S2W-1:0] s_abcd;
  logic [S1W-1:0] e_d1_d;
  logic [S1W-1:0] e_d1_q;
  logic [S1W-1:0] e_d2_q;

  parl_add_reg2 #(
    .A_W      (OW),
    .B_W      (OW),
    .OUT_W    (S1W),
    .SIGNED_EN(PARL_ADD_SIGNED)
  ) u_ab (
    .clk_i  (parl_add_top_clk),
    .rst_b_i(parl_add_top_rst_b),
    .a_i    (parl_add_top_in_a_i),
    .b_i    (parl_add_top_in_b_i),
    .sum_o  (s_ab)
  );

  parl_add_reg2 #(
    .A_W      (OW),
    .B_W      (OW),
    .OUT_W    (S1W),
    .SIGNED_EN(PARL_ADD_SIGNED)
  ) u_cd (
    .clk_i  (parl_add_top_clk),
    .rst_b_i(parl_add_top_rst_b),
    .a_i    (parl_add_top_in_c_i),
    .b_i    (parl_add_top_in_d_i),
    .sum_o  (s_cd)
  );

  // e rides alongside the tree so it meets s_abcd in the last stage.
  assign e_d1_d = {PARL_ADD_SIGNED & parl_add_top_in_e_i[OW-1],
                   parl_add_top_in_e_i};

  always_ff @(posedge parl_add_top_clk) begin
    if (!parl_add_top_rst_b) begin
      e_d1_q <= '0;
      e_d2_q <= '0;
    end else begin
      e_d1_q <= e_d1_d;
      e_d2_q <= e_d1_q;
    end
  end

  parl_add_reg2 #(
    .A_W      (S1W),
    .B_W      (S1W),
    .OUT_W    (S2W),
    .SIGNED_EN(PARL_ADD_SIGNED)
  ) u_abcd (
    .clk_i  (parl_add_top_clk),
    .rst_b_i(parl_add_top_rst_b),
    .a_i    (s_ab),
    .b_i    (s_cd),
    .sum_o  (s_abcd)
  );

  parl_add_reg2 #(
    .A_W      (S2W),
    .B_W      (S1W),
    .OUT_W    (OUTPUT_WIDTH),
    .SIGNED_EN(PARL_ADD_SIGNED)
  ) u_out (
    .clk_i  (parl_add_top_clk),
    .rst_b_i(parl_add_top_rst_b),
    .a_i    (s_abcd),
    .b_i    (e_d2_q),
    .sum_o  (parl_add_top_out_o)
  );

endmodule

// File: tb/tb_parallel_add_5.sv
// Scoreboard bench for parallel_add_5: directed vectors, expected
// sums keyed by the clock edge on which they must appear.
module tb_parallel_add_5;

  localparam int OW = 19;
  localparam int RW = 22;

  typedef struct {
    bit          rst;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [OW-1:0] c;
    logic [OW-1:0] d;
    logic [OW-1:0] e;
    logic [RW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [OW-1:0] a = '0;
  logic [OW-1:0] b = '0;
  logic [OW-1:0] c = '0;
  logic [OW-1:0] d = '0;
  logic [OW-1:0] e = '0;
  logic [RW-1:0] out;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_mem [int];
  vec_t vecs [$];

  parallel_add_5 dut (
    .parl_add_top_clk   (clk),
    .parl_add_top_rst_b (rst_b),
    .parl_add_top_in_a_i(a),
    .parl_add_top_in_b_i(b),
    .parl_add_top_in_c_i(c),
    .parl_add_top_in_d_i(d),
    .parl_add_top_in_e_i(e),
    .parl_add_top_out_o (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare whatever sum is due on the edge just taken.
  always @(posedge clk) begin
    int ed;
    ed = cyc;
    #1;
    if (exp_mem.exists(ed)) begin
      checks++;
      if (out !== exp_mem[ed]) begin
        failures++;
        $display("FAIL out@edge%0d got=%h exp=%h", ed, out, exp_mem[ed]);
      end
      exp_mem.delete(ed);
    end
  end

  task automatic add_vec(input bit r,
                         input logic [OW-1:0] va, input logic [OW-1:0] vb,
                         input logic [OW-1:0] vc, input logic [OW-1:0] vd,
                         input logic [OW-1:0] ve, input logic [RW-1:0] vx);
    vec_t v;
    v.rst = r; v.a = va; v.b = vb; v.c = vc; v.d = vd; v.e = ve;
    v.exp = vx;
    vecs.push_back(v);
  endtask

  initial begin
    logic [RW-1:0] exp_max;
    logic [RW-1:0] exp_mix;
`ifdef PARL_ADD_SIGNED_EN
    exp_max = 22'h3FFFFB;
    exp_mix = 22'h33FFFF;
`else
    exp_max = 22'h27FFFB;
    exp_mix = 22'h13FFFF;
`endif
    for (int i = 0; i < 3; i++)
      add_vec(1'b1, 'x, 'x, 'x, 'x, 'x, '0);
    add_vec(1'b0, 0, 0, 0, 0, 0, 22'h0);
    add_vec(1'b0, 19'h2FFF, 19'h2FFF, 19'h2FFF, 19'h2FFF, 19'h2FFF,
            22'h00EFFB);
    add_vec(1'b0, 19'h1000, 19'h1000, 19'h1000, 19'h1000, 19'h1000,
            22'h005000);
    add_vec(1'b0, 19'h2000, 19'h2000, 19'h2000, 19'h2000, 19'h2000,
            22'h00A000);
    add_vec(1'b0, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF,
            exp_max);
    add_vec(1'b0, 1, 2, 3, 4, 5, 22'd15);
    add_vec(1'b0, 19'h3FFFF, 19'h40000, 19'h40000, 19'h40000, 19'h40000,
            exp_mix);
    for (int k = 1; k <= 8; k++)
      add_vec(1'b0, OW'(k), 0, 0, 0, 0, RW'(k));
    add_vec(1'b1, 19'h11111, 19'h11111, 0, 0, 0, '0);
    add_vec(1'b0, 19'h00100, 0, 0, 0, 0, 22'h000100);
    add_vec(1'b0, 19'h12345, 19'h34321, 19'h0F0F0, 19'h30707, 19'h00001,
            22'h085E5E);
    for (int i = 0; i < 4; i++)
      add_vec(1'b0, 0, 0, 0, 0, 0, 22'h0);

    // Driver: inputs change on the falling edge, sampled on the next rise.
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_b = ~vecs[i].rst;
      a = vecs[i].a;
      b = vecs[i].b;
      c = vecs[i].c;
      d = vecs[i].d;
      e = vecs[i].e;
      if (vecs[i].rst) begin
        exp_mem[cyc]     = '0;
        exp_mem[cyc + 1] = '0;
        exp_mem[cyc + 2] = '0;
      end else begin
        exp_mem[cyc + 2] = vecs[i].exp;
      end
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_mem.num() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", exp_mem.num());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
